// File: rtl/lcd_hex_display_pkg.sv
// Shared definitions for the LCD hex display: state encodings, HD44780 command
// bytes, microsecond delays, nibble timing and the hex-to-ASCII helper.
package lcd_hex_display_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_INIT3_A,
    ST_INIT3_B,
    ST_INIT3_C,
    ST_INIT2,
    ST_CFG,
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_HI,
    ST_WR_LO
  } state_e;

  typedef enum logic [1:0] {
    PH_START,
    PH_BUSY,
    PH_DELAY
  } phase_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_HIGH,
    W_HOLD,
    W_GAP
  } wstate_e;

  typedef struct packed {
    logic       byte_mode;
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  localparam logic [7:0] CMD_INIT8    = 8'h03;
  localparam logic [7:0] CMD_INIT4    = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ADDR0    = 8'h80;

  localparam int unsigned US_PWR     = 15000;
  localparam int unsigned US_INIT3_A = 4100;
  localparam int unsigned US_INIT3_B = 100;
  localparam int unsigned US_CMD     = 40;
  localparam int unsigned US_CLEAR   = 1640;

  localparam int unsigned SETUP_CYC  = 2;
  localparam int unsigned E_HIGH_CYC = 12;
  localparam int unsigned HOLD_CYC   = 2;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives E/RS/D for one nibble or one byte (upper nibble first) to a 4-bit
// HD44780 bus; pulses done for one cycle once the final hold time has elapsed.
module lcd_nibble_writer
  import lcd_hex_display_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  lcd_req_t   req,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d
);

  localparam int unsigned CNT_MAX = (CLK_PER_US > E_HIGH_CYC) ? CLK_PER_US : E_HIGH_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  wstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [3:0]    d_q, d_d;
  logic [3:0]    lo_nib_q, lo_nib_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    e_d      = e_q;
    rs_d     = rs_q;
    d_d      = d_q;
    lo_nib_d = lo_nib_q;
    last_d   = last_q;
    done_d   = 1'b0;
    case (state_q)
      W_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = W_SETUP;
          rs_d     = req.rs;
          lo_nib_d = req.data[3:0];
          d_d      = req.byte_mode ? req.data[7:4] : req.data[3:0];
          last_d   = ~req.byte_mode;
        end
      end
      W_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = W_HIGH;
          e_d     = 1'b1;
          cnt_d   = '0;
        end
      end
      W_HIGH: begin
        if (cnt_q == CW'(E_HIGH_CYC - 1)) begin
          state_d = W_HOLD;
          e_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      W_HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = W_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = W_GAP;
          end
        end
      end
      W_GAP: begin
        // 1 us between the two nibbles of a byte
        if (cnt_q == CW'(CLK_PER_US - 1)) begin
          state_d = W_SETUP;
          d_d     = lo_nib_q;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = W_IDLE;
        e_d     = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= W_IDLE;
      cnt_q    <= '0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      d_q      <= 4'h0;
      lo_nib_q <= 4'h0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      d_q      <= d_d;
      lo_nib_q <= lo_nib_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_hex_display.sv
// Initialises a 4-bit HD44780 LCD after power-up, then shows each accepted
// byte as two uppercase hex characters at DDRAM address 0.
module lcd_hex_display
  import lcd_hex_display_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oBusy,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D
);

  localparam int unsigned DW = $clog2(US_PWR * CLK_PER_US + 1);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [1:0]    cfg_idx_q, cfg_idx_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  lcd_req_t      req_q, req_d;
  logic          busy_q, busy_d;

  logic          wr_done;
  int unsigned   dly_us_c;
  logic [DW-1:0] dly_end_c;
  lcd_req_t      req_c;
  logic [7:0]    cfg_byte_c;

  // Per-state wait length and bus transfer
  always_comb begin
    case (cfg_idx_q)
      2'd0:    cfg_byte_c = CMD_FUNC_SET;
      2'd1:    cfg_byte_c = CMD_ENTRY;
      2'd2:    cfg_byte_c = CMD_DISP_ON;
      default: cfg_byte_c = CMD_CLEAR;
    endcase

    dly_us_c = US_CMD;
    req_c    = '{byte_mode: 1'b1, rs: 1'b0, data: CMD_ADDR0};
    case (state_q)
      ST_PWR_WAIT: dly_us_c = US_PWR;
      ST_INIT3_A: begin
        dly_us_c = US_INIT3_A;
        req_c    = '{byte_mode: 1'b0, rs: 1'b0, data: CMD_INIT8};
      end
      ST_INIT3_B: begin
        dly_us_c = US_INIT3_B;
        req_c    = '{byte_mode: 1'b0, rs: 1'b0, data: CMD_INIT8};
      end
      ST_INIT3_C: req_c = '{byte_mode: 1'b0, rs: 1'b0, data: CMD_INIT8};
      ST_INIT2:   req_c = '{byte_mode: 1'b0, rs: 1'b0, data: CMD_INIT4};
      ST_CFG: begin
        dly_us_c = (cfg_idx_q == 2'd3) ? US_CLEAR : US_CMD;
        req_c    = '{byte_mode: 1'b1, rs: 1'b0, data: cfg_byte_c};
      end
      ST_WR_HI: req_c = '{byte_mode: 1'b1, rs: 1'b1, data: hex_ascii(data_q[7:4])};
      ST_WR_LO: req_c = '{byte_mode: 1'b1, rs: 1'b1, data: hex_ascii(data_q[3:0])};
      default: ;
    endcase
    dly_end_c = DW'(dly_us_c * CLK_PER_US - 1);
  end

  // Each non-idle state: start a transfer, wait for done, then wait its delay
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dly_d     = dly_q;
    cfg_idx_d = cfg_idx_q;
    data_d    = data_q;
    start_d   = 1'b0;
    req_d     = req_q;
    case (phase_q)
      PH_START: begin
        if (state_q != ST_IDLE) begin
          start_d = 1'b1;
          req_d   = req_c;
          phase_d = PH_BUSY;
        end
      end
      PH_BUSY: begin
        if (wr_done) begin
          phase_d = PH_DELAY;
          dly_d   = '0;
        end
      end
      PH_DELAY: begin
        if (dly_q == dly_end_c) begin
          dly_d   = '0;
          phase_d = PH_START;
          case (state_q)
            ST_PWR_WAIT: state_d = ST_INIT3_A;
            ST_INIT3_A:  state_d = ST_INIT3_B;
            ST_INIT3_B:  state_d = ST_INIT3_C;
            ST_INIT3_C:  state_d = ST_INIT2;
            ST_INIT2: begin
              state_d   = ST_CFG;
              cfg_idx_d = 2'd0;
            end
            ST_CFG: begin
              if (cfg_idx_q == 2'd3) state_d = ST_IDLE;
              else                   cfg_idx_d = cfg_idx_q + 2'd1;
            end
            ST_WR_ADDR: state_d = ST_WR_HI;
            ST_WR_HI:   state_d = ST_WR_LO;
            default:    state_d = ST_IDLE;
          endcase
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      default: phase_d = PH_START;
    endcase

    // Capture only from IDLE; strobes in any other state are dropped
    if (state_q == ST_IDLE && iValid) begin
      data_d  = iData;
      state_d = ST_WR_ADDR;
      phase_d = PH_START;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_PWR_WAIT;
      phase_q   <= PH_DELAY;
      dly_q     <= '0;
      cfg_idx_q <= 2'd0;
      data_q    <= 8'h00;
      start_q   <= 1'b0;
      req_q     <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dly_q     <= dly_d;
      cfg_idx_q <= cfg_idx_d;
      data_q    <= data_d;
      start_q   <= start_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
    end
  end

  lcd_nibble_writer #(
    .CLK_PER_US(CLK_PER_US)
  ) u_writer (
    .clk   (Clock),
    .rst   (Reset),
    .start (start_q),
    .req   (req_q),
    .done  (wr_done),
    .lcd_e (oLCD_E),
    .lcd_rs(oLCD_RS),
    .lcd_d (oLCD_D)
  );

  assign oBusy   = busy_q;
  assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Bench for lcd_hex_display: decodes E pulses into {RS,nibble} records and
// compares them with the expected LCD transfer list, plus timing and latency.
module tb_lcd_hex_display;

  localparam int unsigned CPU       = 1;
  localparam int unsigned NIB_CYC   = 2 + 12 + 2;
  localparam int unsigned HS_CYC    = 3;
  localparam int unsigned BYTE_CYC  = HS_CYC + 2 * NIB_CYC + CPU + 40 * CPU;
  localparam int unsigned WRITE_LAT = 3 * BYTE_CYC;
  localparam int unsigned CLEAR_TO_IDLE = 2 + 1 + 1640 * CPU;
  localparam int          INIT_BUDGET   = 30000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] iData = 8'h00;
  logic       iValid = 1'b0;
  logic       oBusy, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_D;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];

  logic       prev_e = 1'b0;
  logic [3:0] prev_d = 4'h0;
  logic       prev_rs = 1'b0;
  int         high_cnt = 0;
  int         setup_cnt = 0;
  int         hold_cnt = 0;
  bit         hold_act = 1'b0;
  int         since_fall = 0;

  lcd_hex_display #(.CLK_PER_US(CPU)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .iData  (iData),
    .iValid (iValid),
    .oBusy  (oBusy),
    .oLCD_E (oLCD_E),
    .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW),
    .oLCD_D (oLCD_D)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    string hx;
    hx = "0123456789ABCDEF";
    return 8'(hx.getc(int'(n)));
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic push_write(input logic [7:0] b);
    push_byte(1'b0, 8'h80);
    push_byte(1'b1, to_ascii(b[7:4]));
    push_byte(1'b1, to_ascii(b[3:0]));
  endtask

  // Pulse decoder and per-cycle timing checks
  always @(negedge Clock) begin
    bit changed;
    logic [4:0] e;
    if (Reset) begin
      prev_e    = 1'b0;
      high_cnt  = 0;
      setup_cnt = 0;
      hold_cnt  = 0;
      hold_act  = 1'b0;
      prev_d    = oLCD_D;
      prev_rs   = oLCD_RS;
    end else begin
      changed = (oLCD_D != prev_d) || (oLCD_RS != prev_rs);
      since_fall++;
      if (oLCD_E && !prev_e) begin
        chk(setup_cnt >= 2, "setup", setup_cnt, 2);
        chk(oLCD_RW == 1'b0, "rw", oLCD_RW, 0);
        obs_q.push_back({oLCD_RS, oLCD_D});
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", {oLCD_RS, oLCD_D}, 0);
        end else begin
          e = exp_q.pop_front();
          chk({oLCD_RS, oLCD_D} == e, "nibble", {oLCD_RS, oLCD_D}, e);
        end
        high_cnt = 1;
      end else if (oLCD_E) begin
        high_cnt++;
        chk(!changed, "data_during_e", {oLCD_RS, oLCD_D}, {prev_rs, prev_d});
      end else if (prev_e) begin
        chk(high_cnt == 12, "e_width", high_cnt, 12);
        chk(!changed, "hold_at_fall", {oLCD_RS, oLCD_D}, {prev_rs, prev_d});
        hold_cnt   = 1;
        hold_act   = 1'b1;
        since_fall = 0;
      end else if (changed) begin
        if (hold_act) chk(hold_cnt >= 2, "hold", hold_cnt, 2);
        hold_act  = 1'b0;
        setup_cnt = 1;
      end else begin
        setup_cnt++;
        hold_cnt++;
      end
      prev_e  = oLCD_E;
      prev_d  = oLCD_D;
      prev_rs = oLCD_RS;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (oBusy !== 1'b0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    chk(oBusy === 1'b0, name, oBusy, 0);
  endtask

  task automatic check_init_done();
    wait_idle(INIT_BUDGET, "init_idle");
    #1;
    chk(since_fall == CLEAR_TO_IDLE, "clear_wait", since_fall, CLEAR_TO_IDLE);
    chk(exp_q.size() == 0, "init_nibbles_left", exp_q.size(), 0);
  endtask

  // One write; optionally pulses junk iValid while busy at cycle inj_at
  task automatic do_write(input logic [7:0] b, input bit inject, input logic [7:0] junk,
                          input int inj_at);
    int lat;
    lat = 0;
    obs_q.delete();
    @(negedge Clock);
    chk(oBusy == 1'b0, "idle_before_write", oBusy, 0);
    push_write(b);
    iData  = b;
    iValid = 1'b1;
    @(negedge Clock);
    iValid = 1'b0;
    iData  = 8'h00;
    while (oBusy === 1'b1 && lat < 2000) begin
      if (inject && lat == inj_at) begin
        iData  = junk;
        iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
      @(negedge Clock);
      lat++;
    end
    iValid = 1'b0;
    chk(lat == WRITE_LAT, "write_latency", lat, WRITE_LAT);
    chk(exp_q.size() == 0, "write_nibbles_left", exp_q.size(), 0);
    repeat (30) @(negedge Clock);
    chk(oBusy == 1'b0, "stays_idle", oBusy, 0);
  endtask

  task automatic check_obs(input logic [7:0] b_hi, input logic [7:0] b_lo);
    logic [4:0] a, c;
    chk(obs_q.size() == 6, "obs_count", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      a = obs_q[0]; c = obs_q[1];
      chk({a[4], c[4], a[3:0], c[3:0]} == {2'b00, 8'h80}, "addr_byte",
          {a[4], c[4], a[3:0], c[3:0]}, {2'b00, 8'h80});
      a = obs_q[2]; c = obs_q[3];
      chk({a[4], c[4], a[3:0], c[3:0]} == {2'b11, b_hi}, "hi_char",
          {a[4], c[4], a[3:0], c[3:0]}, {2'b11, b_hi});
      a = obs_q[4]; c = obs_q[5];
      chk({a[4], c[4], a[3:0], c[3:0]} == {2'b11, b_lo}, "lo_char",
          {a[4], c[4], a[3:0], c[3:0]}, {2'b11, b_lo});
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge Clock);
    #1;
    chk(oBusy == 1'b1, "rst_busy", oBusy, 1);
    chk(oLCD_E == 1'b0, "rst_e", oLCD_E, 0);
    chk(oLCD_RS == 1'b0, "rst_rs", oLCD_RS, 0);
    chk(oLCD_D == 4'h0, "rst_d", oLCD_D, 0);
    chk(oLCD_RW == 1'b0, "rst_rw", oLCD_RW, 0);
    obs_q.delete();
    push_init();
    Reset = 1'b0;
    check_init_done();
    chk(obs_q.size() == 12, "init_pulse_count", obs_q.size(), 12);

    do_write(8'h5A, 1'b0, 8'h00, 0);
    check_obs(8'h35, 8'h41);

    do_write(8'h0F, 1'b1, 8'hF0, 5);
    check_obs(8'h30, 8'h46);

    // strobe coinciding with the final cycle of the WR_LO wait
    do_write(8'h09, 1'b1, 8'h77, int'(WRITE_LAT) - 1);
    check_obs(8'h30, 8'h39);

    do_write(8'hA0, 1'b0, 8'h00, 0);
    check_obs(8'h41, 8'h30);

    // Reset in the middle of the WR_HI E pulse
    obs_q.delete();
    @(negedge Clock);
    push_write(8'h3C);
    iData  = 8'h3C;
    iValid = 1'b1;
    @(negedge Clock);
    iValid = 1'b0;
    n = 0;
    while (obs_q.size() < 3 && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    chk(obs_q.size() >= 3, "reach_wr_hi", obs_q.size(), 3);
    @(negedge Clock);
    chk(oLCD_E == 1'b1, "e_high_before_reset", oLCD_E, 1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    chk(oLCD_E == 1'b0, "e_low_after_reset", oLCD_E, 0);
    chk(oBusy == 1'b1, "busy_after_reset", oBusy, 1);
    chk(oLCD_D == 4'h0, "d_after_reset", oLCD_D, 0);
    chk(oLCD_RS == 1'b0, "rs_after_reset", oLCD_RS, 0);
    exp_q.delete();
    obs_q.delete();
    push_init();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_init_done();
    chk(obs_q.size() == 12, "reinit_pulse_count", obs_q.size(), 12);

    do_write(8'hC3, 1'b0, 8'h00, 0);
    check_obs(8'h43, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hex_display.md
LCD_HEX_DISPLAY -- requirements
Module: lcd_hex_display

Interface
REQ-001 Parameter CLK_PER_US, default 50, SHALL give clock cycles per microsecond; all LCD delays scale from it.
REQ-002 Clock  input  1  system clock; all logic on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 iData  input  8  byte to display, normally the ALU LED register output.
REQ-005 iValid  input  1  strobe: iData is new this cycle.
REQ-006 oBusy  output  1  high while initialising or writing.
REQ-007 oLCD_E  output  1  LCD enable strobe.
REQ-008 oLCD_RS  output  1  0 = command, 1 = data.
REQ-009 oLCD_RW  output  1  constant 0, write only.
REQ-010 oLCD_D  output  4  LCD data nibble; upper nibble first.

Function
REQ-011 State sequence SHALL be PWR_WAIT -> INIT3_A -> INIT3_B -> INIT3_C -> INIT2 -> CFG -> IDLE -> WR_ADDR -> WR_HI -> WR_LO -> IDLE.
REQ-012 PWR_WAIT SHALL last 15000*CLK_PER_US cycles with oLCD_E=0.
REQ-013 INIT3_A/B/C SHALL each issue the single nibble 0x3 (RS=0), followed by waits of 4100, 100 and 40 us respectively.
REQ-014 INIT2 SHALL issue the single nibble 0x2, then wait 40 us.
REQ-015 CFG SHALL issue the full bytes 0x28, 0x06, 0x0C and 0x01 (RS=0), in that order.
REQ-016 Each CFG byte SHALL be followed by a 40 us wait, except 0x01, which SHALL be followed by a 1640 us wait.
REQ-017 Nibble timing SHALL be:
- data/RS stable 2 cycles before E rises;
- E high 12 cycles;
- data held 2 cycles after E falls.
REQ-018 Between the two nibbles of a byte there SHALL be a 1 us gap.
REQ-019 oBusy SHALL be high in every state except IDLE.
REQ-020 In IDLE, iValid=1 SHALL capture iData into an internal register and move to WR_ADDR the next cycle.
REQ-021 iValid while oBusy=1 SHALL be ignored: no queueing and no change to the captured value.
REQ-022 WR_ADDR SHALL write command 0x80 (DDRAM address 0).
REQ-023 WR_HI and WR_LO SHALL write ASCII for the upper and lower captured nibble with RS=1.
REQ-024 Nibble-to-ASCII mapping: values 0-9 SHALL map to 0x30+n; values A-F SHALL map to 0x37+n (uppercase).
REQ-025 Each byte in WR_ADDR, WR_HI and WR_LO SHALL be followed by a 40 us wait.
REQ-026 The delay counter SHALL be wide enough for 15000*CLK_PER_US without wrap-around.
REQ-027 Simultaneous iValid and the last cycle of the WR_LO wait SHALL be ignored; the capture is accepted only from IDLE.
REQ-028 Write latency from iValid acceptance to IDLE SHALL be deterministic, and the bench SHALL check it against the computed sum.

Reset
REQ-029 Reset SHALL force PWR_WAIT and clear the delay counter.
REQ-030 Reset SHALL drive oLCD_E=0, oLCD_RS=0, oLCD_D=0, oBusy=1 and the captured byte to 0x00.
REQ-031 Reset asserted mid-write or mid-init SHALL abort that operation at once and restart the full init sequence.

Structure
REQ-032 The state encodings, LCD command bytes and microsecond delay constants SHALL live in the shared definitions include file.
REQ-033 A single sub-module, lcd_nibble_writer, SHALL generate E/RS/D timing for one nibble or one byte.
REQ-034 lcd_nibble_writer SHALL handshake with the parent via a start input and a done output.

Verification (CLK_PER_US=1)
REQ-035 Reset held 3 cycles, then released -> oBusy=1; the E pulse sequence reads nibbles 3,3,3,2,2,8,0,6,0,C,0,1 with RS=0; oBusy falls only after the 1640-cycle clear wait.
REQ-036 After init, iData=0x5A with iValid for 1 cycle -> RS=0 nibbles 8,0; then RS=1 nibbles 3,5,4,1; oBusy returns low.
REQ-037 iData=0x0F, then 0xF0 pulsed while busy -> only "0F" (0x30, 0x46) is written; 0xF0 is never displayed.
REQ-038 Reset asserted during WR_HI -> E low the next cycle; the full init sequence repeats.
REQ-039 iData=0x09 and 0xA0 -> ASCII bytes 0x30,0x39 and 0x41,0x30 respectively.
REQ-040 An E-high width monitor SHALL confirm exactly 12 cycles, and setup/hold SHALL be at least 2 cycles, on every pulse.
